// File: rtl/fetch_sequencer.sv
// fetch_sequencer: single-port instruction fetch front end.
// Issues one read request at a time to instruction memory, presents each
// returned word as PC/Instruction until the consumer takes it, and reacts
// to redirects (branch/jump), halt and start commands.
// mem_req and mem_addr are decoded straight from state registers so the
// request is visible in the same cycle the sequencer enters FETCH; every
// other output is a register.

module fetch_sequencer #(
  parameter bit AUTO_START = 1'b1,
  parameter int COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [15:0]        boot_addr,
  input  logic               halt,
  input  logic               redirect_valid,
  input  logic [15:0]        redirect_pc,
  input  logic               stall,
  output logic               mem_req,
  output logic [15:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [31:0]        mem_rdata,
  output logic [15:0]        PC,
  output logic [31:0]        Instruction,
  output logic               instr_valid,
  output logic               busy,
  output logic               halted,
  output logic [COUNT_W-1:0] fetch_count
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FETCH  = 2'd1,
    ST_HOLD   = 2'd2,
    ST_HALTED = 2'd3
  } state_t;

  state_t             r_state;
  logic [15:0]        r_fetch_pc;
  logic [15:0]        r_pc;
  logic [31:0]        r_instr;
  logic               r_valid;
  logic               r_busy;
  logic               r_halted;
  logic [COUNT_W-1:0] r_count;
  // Set by reset, cleared on the first clock: lets AUTO_START kick off
  // exactly one fetch from address zero after each reset release.
  logic               r_auto_pend;

  // Instruction addresses are word aligned; low two bits are forced to zero.
  logic [15:0]        w_boot_pc;
  logic [15:0]        w_redir_pc;
  logic [15:0]        w_next_pc;
  logic               w_launch;
  logic               w_count_full;

  assign w_boot_pc    = boot_addr & 16'hFFFC;
  assign w_redir_pc   = redirect_pc & 16'hFFFC;
  // 16-bit add wraps naturally: 0xFFFC + 4 = 0x0000.
  assign w_next_pc    = r_fetch_pc + 16'd4;
  // halt outranks start, so a start seen together with halt is dropped.
  assign w_launch     = start & ~halt;
  assign w_count_full = &r_count;

  // Sequencer FSM: state, fetch pointer, presented instruction and counters.
  // NOTE: every register here is assigned with <= so all of them update from
  // the same pre-edge values; a blocking = would let later statements see
  // half-updated state and simulate differently from the synthesized flops.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: rst is asynchronous, so every register (including the held
    // instruction) is cleared in the reset branch, independent of clk.
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_fetch_pc  <= 16'h0000;
      r_pc        <= 16'h0000;
      r_instr     <= 32'h0000_0000;
      r_valid     <= 1'b0;
      r_busy      <= 1'b0;
      r_halted    <= 1'b0;
      r_count     <= '0;
      r_auto_pend <= AUTO_START;
    end else begin
      r_auto_pend <= 1'b0;
      case (r_state)
        ST_IDLE, ST_HALTED: begin
          // Redirects are meaningless while not fetching and are ignored.
          if (w_launch) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= w_boot_pc;
            r_count    <= '0;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
          end else if (r_auto_pend) begin
            r_state    <= ST_FETCH;
            r_fetch_pc <= 16'h0000;
            r_count    <= '0;
            r_busy     <= 1'b1;
            r_halted   <= 1'b0;
          end
        end

        ST_FETCH: begin
          if (halt) begin
            // Outstanding request is abandoned; a same-cycle ack is dropped.
            r_state  <= ST_HALTED;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (redirect_valid) begin
            // Re-issue at the new target; any same-cycle read data is stale.
            r_fetch_pc <= w_redir_pc;
            r_valid    <= 1'b0;
          end else if (mem_ack) begin
            r_state    <= ST_HOLD;
            r_pc       <= r_fetch_pc;
            r_instr    <= mem_rdata;
            r_valid    <= 1'b1;
            r_fetch_pc <= w_next_pc;
          end
        end

        ST_HOLD: begin
          if (halt) begin
            r_state  <= ST_HALTED;
            r_valid  <= 1'b0;
            r_busy   <= 1'b0;
            r_halted <= 1'b1;
          end else if (redirect_valid) begin
            // Held instruction is on the wrong path: drop it without counting.
            r_state    <= ST_FETCH;
            r_fetch_pc <= w_redir_pc;
            r_valid    <= 1'b0;
          end else if (!stall) begin
            // Consumer took the instruction this cycle.
            r_state <= ST_FETCH;
            r_valid <= 1'b0;
            if (!w_count_full) begin
              r_count <= r_count + COUNT_W'(1);
            end
          end
        end

        default: begin
          r_state  <= ST_IDLE;
          r_valid  <= 1'b0;
          r_busy   <= 1'b0;
          r_halted <= 1'b0;
        end
      endcase
    end
  end

  // Request interface is a direct decode of the state registers.
  assign mem_req     = (r_state == ST_FETCH);
  assign mem_addr    = r_fetch_pc;

  assign PC          = r_pc;
  assign Instruction = r_instr;
  assign instr_valid = r_valid;
  assign busy        = r_busy;
  assign halted      = r_halted;
  assign fetch_count = r_count;

endmodule

// File: tb/tb_fetch_sequencer.sv
// tb_fetch_sequencer: directed scenarios followed by randomized traffic,
// all compared against a behavioural model of the fetch rules.
// A second instance (AUTO_START=0, 2-bit counter) covers idle-after-reset
// and counter saturation.

module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b0;

  // Main DUT (AUTO_START=1, COUNT_W=16)
  logic        start = 1'b0;
  logic [15:0] boot_addr = 16'h0000;
  logic        halt = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = 16'h0000;
  logic        stall = 1'b0;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata;
  logic        mem_req;
  logic [15:0] mem_addr;
  logic [15:0] PC;
  logic [31:0] Instruction;
  logic        instr_valid;
  logic        busy;
  logic        halted;
  logic [15:0] fetch_count;

  // Second DUT (AUTO_START=0, COUNT_W=2)
  logic        b_start = 1'b0;
  logic [15:0] b_boot_addr = 16'h0000;
  logic        b_stall = 1'b0;
  logic        b_mem_ack = 1'b0;
  logic [31:0] b_mem_rdata;
  logic        b_mem_req;
  logic [15:0] b_mem_addr;
  logic [15:0] b_PC;
  logic [31:0] b_Instruction;
  logic        b_instr_valid;
  logic        b_busy;
  logic        b_halted;
  logic [1:0]  b_fetch_count;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  // Instruction memory contents: the four program words, then a hash.
  function automatic logic [31:0] mem_word(input logic [15:0] a);
    case (a)
      16'h0000: mem_word = 32'h0000_0020;
      16'h0004: mem_word = 32'h0000_0021;
      16'h0008: mem_word = 32'h0000_0031;
      16'h000C: mem_word = 32'h0000_0005;
      default:  mem_word = {a ^ 16'h5A5A, ~a};
    endcase
  endfunction

  assign mem_rdata   = mem_word(mem_addr);
  assign b_mem_rdata = mem_word(b_mem_addr);

  fetch_sequencer #(.AUTO_START(1'b1), .COUNT_W(16)) dut (
    .clk(clk), .rst(rst), .start(start), .boot_addr(boot_addr), .halt(halt),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .PC(PC), .Instruction(Instruction), .instr_valid(instr_valid), .busy(busy),
    .halted(halted), .fetch_count(fetch_count)
  );

  fetch_sequencer #(.AUTO_START(1'b0), .COUNT_W(2)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .boot_addr(b_boot_addr), .halt(1'b0),
    .redirect_valid(1'b0), .redirect_pc(16'h0000), .stall(b_stall),
    .mem_req(b_mem_req), .mem_addr(b_mem_addr), .mem_ack(b_mem_ack), .mem_rdata(b_mem_rdata),
    .PC(b_PC), .Instruction(b_Instruction), .instr_valid(b_instr_valid), .busy(b_busy),
    .halted(b_halted), .fetch_count(b_fetch_count)
  );

  // ---------------- behavioural model of the main DUT ----------------
  // Activity: 0 idle, 1 waiting for read data, 2 presenting a word, 3 halted.
  localparam int A_IDLE = 0, A_WAIT = 1, A_SHOW = 2, A_HALT = 3;
  int          m_act;
  int          m_next_addr;   // address of the next read, 0..65535
  int          m_shown_pc;
  logic [31:0] m_shown_word;
  bit          m_shown;
  int          m_consumed;    // saturates at 65535
  bit          m_first_clock;

  task automatic model_reset();
    m_act         = A_IDLE;
    m_next_addr   = 0;
    m_shown_pc    = 0;
    m_shown_word  = 32'h0;
    m_shown       = 1'b0;
    m_consumed    = 0;
    m_first_clock = 1'b1;
  endtask

  // One clock's worth of the fetch rules, using the inputs now driven.
  task automatic model_step();
    bit was_first;
    was_first     = m_first_clock;
    m_first_clock = 1'b0;
    if (m_act == A_IDLE || m_act == A_HALT) begin
      if (start && !halt) begin
        m_act       = A_WAIT;
        m_next_addr = (int'(boot_addr) / 4) * 4;
        m_consumed  = 0;
      end else if (m_act == A_IDLE && was_first) begin
        m_act       = A_WAIT;
        m_next_addr = 0;
        m_consumed  = 0;
      end
    end else if (halt) begin
      m_act   = A_HALT;
      m_shown = 1'b0;
    end else if (redirect_valid) begin
      m_act       = A_WAIT;
      m_next_addr = (int'(redirect_pc) / 4) * 4;
      m_shown     = 1'b0;
    end else if (m_act == A_WAIT) begin
      if (mem_ack) begin
        m_act        = A_SHOW;
        m_shown_pc   = m_next_addr;
        m_shown_word = mem_word(16'(m_next_addr));
        m_shown      = 1'b1;
        m_next_addr  = (m_next_addr + 4) % 65536;
      end
    end else if (!stall) begin
      m_act      = A_WAIT;
      m_shown    = 1'b0;
      m_consumed = (m_consumed < 65535) ? m_consumed + 1 : 65535;
    end
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    check("mem_req",     32'(mem_req),     32'(m_act == A_WAIT));
    check("mem_addr",    32'(mem_addr),    32'(m_next_addr));
    check("PC",          32'(PC),          32'(m_shown_pc));
    check("Instruction", Instruction,      m_shown_word);
    check("instr_valid", 32'(instr_valid), 32'(m_shown));
    check("busy",        32'(busy),        32'(m_act == A_WAIT || m_act == A_SHOW));
    check("halted",      32'(halted),      32'(m_act == A_HALT));
    check("fetch_count", 32'(fetch_count), 32'(m_consumed));
  endtask

  // Advance one clock and compare everything shortly after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rst = 1'b0;
    model_reset();
    #2;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  logic [15:0] exp_pc   [4] = '{16'h0000, 16'h0004, 16'h0008, 16'h000C};
  logic [31:0] exp_word [4] = '{32'h20, 32'h21, 32'h31, 32'h05};

  initial begin
    // Reset state
    model_reset();
    #12;
    compare_all();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // Straight-line program, memory acks every request, no stall
    mem_ack = 1'b1;
    tick();
    check("auto_start_fetch_addr", 32'(mem_addr), 32'h0);
    for (int i = 0; i < 4; i++) begin
      tick();
      check("prog_pc",   32'(PC), 32'(exp_pc[i]));
      check("prog_word", Instruction, exp_word[i]);
      tick();
    end
    check("prog_count", 32'(fetch_count), 32'd4);

    // Stall while presenting PC 0x0004
    do_reset();
    tick(); tick(); tick(); tick();
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("stall_pc",    32'(PC), 32'h4);
      check("stall_valid", 32'(instr_valid), 32'h1);
      check("stall_req",   32'(mem_req), 32'h0);
      check("stall_count", 32'(fetch_count), 32'h1);
    end
    stall = 1'b0;
    tick();
    check("release_addr", 32'(mem_addr), 32'h8);
    check("release_req",  32'(mem_req), 32'h1);

    // Redirect in the same cycle as the ack for 0x0008
    redirect_valid = 1'b1;
    redirect_pc    = 16'h0043;
    tick();
    redirect_valid = 1'b0;
    check("redir_addr",  32'(mem_addr), 32'h40);
    check("redir_valid", 32'(instr_valid), 32'h0);
    tick();
    check("redir_pc", 32'(PC), 32'h40);

    // Halt with an ack arriving in the halt cycle, then restart at 0xFFFC
    tick();
    mem_ack = 1'b0;
    tick();
    check("delayed_req", 32'(mem_req), 32'h1);
    halt    = 1'b1;
    mem_ack = 1'b1;
    tick();
    halt    = 1'b0;
    mem_ack = 1'b0;
    check("halt_halted", 32'(halted), 32'h1);
    check("halt_req",    32'(mem_req), 32'h0);
    tick();
    check("halt_stays", 32'(halted), 32'h1);
    start     = 1'b1;
    boot_addr = 16'hFFFC;
    tick();
    start = 1'b0;
    check("boot_addr_fffc", 32'(mem_addr), 32'hFFFC);
    check("boot_count",     32'(fetch_count), 32'h0);
    mem_ack = 1'b1;
    tick();
    check("wrap_pc0", 32'(PC), 32'hFFFC);
    tick();
    tick();
    check("wrap_pc1",   32'(PC), 32'h0000);
    check("wrap_word1", Instruction, 32'h20);

    // Asynchronous reset between edges while presenting an instruction
    #3;
    rst = 1'b0;
    model_reset();
    #1;
    compare_all();
    check("b_rst_busy",  32'(b_busy), 32'h0);
    check("b_rst_req",   32'(b_mem_req), 32'h0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("b_idle_busy", 32'(b_busy), 32'h0);
      check("b_idle_req",  32'(b_mem_req), 32'h0);
    end
    b_start     = 1'b1;
    b_boot_addr = 16'h0013;
    tick();
    b_start = 1'b0;
    check("b_start_addr", 32'(b_mem_addr), 32'h10);
    check("b_start_busy", 32'(b_busy), 32'h1);
    b_mem_ack = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      tick();
      tick();
      check("b_count_sat", 32'(b_fetch_count), (i < 3) ? 32'(i) : 32'd3);
    end
    b_mem_ack = 1'b0;

    // Randomized traffic with occasional mid-cycle reset
    do_reset();
    for (int c = 0; c < 600; c++) begin
      start          = ($urandom_range(7) == 0);
      boot_addr      = ($urandom_range(3) == 0) ? (16'hFFF0 | 16'($urandom_range(15))) : 16'($urandom);
      halt           = ($urandom_range(11) == 0);
      redirect_valid = ($urandom_range(7) == 0);
      redirect_pc    = 16'($urandom);
      stall          = ($urandom_range(2) == 0);
      mem_ack        = ($urandom_range(1) == 0);
      tick();
      if (c % 200 == 199) begin
        #3;
        rst = 1'b0;
        model_reset();
        #1;
        compare_all();
        @(posedge clk);
        #1;
        rst = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
